// File: rtl/mem_access_unit.sv
// MEM-stage requester for the 8-bit data memory: load/store/push/pop with a
// valid/ready request and response, owning the stack pointer.
module mem_access_unit #(
    parameter logic [7:0] STACK_TOP   = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'h80
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       Write_EN,
    output logic       Read_EN,
    output logic [7:0] A,
    output logic [7:0] WD,
    input  logic [7:0] RD,
    output logic [7:0] sp,
    output logic       stk_err,
    input  logic       stk_err_clr,
    output logic [1:0] state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and a presented response is held until taken.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_PUSH  = 2'd2;

    state_t state;
    logic   err_q;
    logic   accept;

    // Ready in RESP follows rsp_ready so a consumed response can overlap the next accept.
    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign state_dbg = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            sp        <= STACK_TOP;
            Write_EN  <= 1'b0;
            Read_EN   <= 1'b0;
            A         <= 8'h00;
            WD        <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            stk_err   <= 1'b0;
        end else begin
            // A rejection later in this block overrides the clear.
            if (stk_err_clr) stk_err <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if ((state == RESP) && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= 8'h00;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                    if (accept) begin
                        state <= ACCESS;
                        err_q <= 1'b0;
                        case (req_op)
                            OP_LOAD: begin
                                A       <= req_addr;
                                Read_EN <= 1'b1;
                            end
                            OP_STORE: begin
                                A        <= req_addr;
                                WD       <= req_wdata;
                                Write_EN <= 1'b1;
                            end
                            OP_PUSH: begin
                                if (sp < STACK_LIMIT) begin
                                    err_q   <= 1'b1;
                                    stk_err <= 1'b1;
                                end else begin
                                    A        <= sp;
                                    WD       <= req_wdata;
                                    sp       <= sp - 8'd1;
                                    Write_EN <= 1'b1;
                                end
                            end
                            default: begin
                                if (sp == STACK_TOP) begin
                                    err_q   <= 1'b1;
                                    stk_err <= 1'b1;
                                end else begin
                                    A       <= sp + 8'd1;
                                    sp      <= sp + 8'd1;
                                    Read_EN <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    // RD was registered by the memory on the falling edge inside ACCESS.
                    Write_EN  <= 1'b0;
                    Read_EN   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= Read_EN ? RD : 8'h00;
                    rsp_err   <= err_q;
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a falling-edge memory model and
// hand-computed expectations for each operation.
module tb_mem_access_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'd0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       Write_EN;
    logic       Read_EN;
    logic [7:0] A;
    logic [7:0] WD;
    logic [7:0] RD = 8'h00;
    logic [7:0] sp;
    logic       stk_err;
    logic       stk_err_clr = 1'b0;
    logic [1:0] state_dbg;

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .Write_EN(Write_EN), .Read_EN(Read_EN),
        .A(A), .WD(WD), .RD(RD), .sp(sp),
        .stk_err(stk_err), .stk_err_clr(stk_err_clr), .state_dbg(state_dbg)
    );

    // Clock and memory model
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Write_EN) mem[A] <= WD;
        if (Read_EN) RD <= mem[A];
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Issue one request, then check the ACCESS cycle and the response one cycle later.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic exp_we, input logic exp_re,
                         input logic [7:0] exp_a, input logic [7:0] exp_data,
                         input logic exp_err, input logic [7:0] exp_sp);
        int waits = 0;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && waits < 20) begin
            @(posedge CLK); #1;
            waits++;
        end
        check({tag, ".accept_timeout"}, 8'(waits >= 20), 8'h0);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        check({tag, ".we"}, 8'(Write_EN), 8'(exp_we));
        check({tag, ".re"}, 8'(Read_EN), 8'(exp_re));
        if (exp_we || exp_re) check({tag, ".a"}, A, exp_a);
        if (exp_we) check({tag, ".wd"}, WD, wdata);
        check({tag, ".sp"}, sp, exp_sp);
        @(posedge CLK); #1;
        check({tag, ".rsp_valid"}, 8'(rsp_valid), 8'h1);
        check({tag, ".strobes_off"}, 8'(Write_EN | Read_EN), 8'h0);
        check({tag, ".rsp_data"}, rsp_data, exp_data);
        check({tag, ".rsp_err"}, 8'(rsp_err), 8'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // Reset values
        #12;
        check("rst.req_ready", 8'(req_ready), 8'h1);
        check("rst.sp", sp, 8'hFF);
        check("rst.strobes", 8'({Write_EN, Read_EN}), 8'h0);
        check("rst.a", A, 8'h00);
        check("rst.wd", WD, 8'h00);
        check("rst.rsp_valid", 8'(rsp_valid), 8'h0);
        check("rst.rsp_data", rsp_data, 8'h00);
        check("rst.rsp_err", 8'(rsp_err), 8'h0);
        check("rst.stk_err", 8'(stk_err), 8'h0);
        check("rst.state", 8'(state_dbg), 8'h0);
        #1 RST = 1'b1;
        @(posedge CLK); #1;

        // Store then load
        do_op("store10", 2'd1, 8'h10, 8'hA5, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hFF);
        do_op("load10",  2'd0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'hFF);

        // Stack ordering
        do_op("push11", 2'd2, 8'h00, 8'h11, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hFE);
        do_op("push22", 2'd2, 8'h00, 8'h22, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b0, 8'hFD);
        do_op("pop1",   2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFE, 8'h22, 1'b0, 8'hFE);
        do_op("pop2",   2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h11, 1'b0, 8'hFF);

        // Underflow and sticky error clear
        do_op("pop_uf", 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF);
        check("uf.stk_err", 8'(stk_err), 8'h1);
        stk_err_clr = 1'b1;
        @(posedge CLK); #1;
        stk_err_clr = 1'b0;
        check("uf.stk_err_clr", 8'(stk_err), 8'h0);

        // Fill the stack, then overflow
        for (int i = 0; i < 128; i++) begin
            do_op($sformatf("fill%0d", i), 2'd2, 8'h00, 8'(i) ^ 8'h5A, 1'b1, 1'b0,
                  8'hFF - 8'(i), 8'h00, 1'b0, 8'hFE - 8'(i));
        end
        do_op("push_of", 2'd2, 8'h00, 8'hEE, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h7F);
        check("of.stk_err", 8'(stk_err), 8'h1);
        do_op("pop_of", 2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 8'h25, 1'b0, 8'h80);

        // Backpressure on a LOAD, with a STORE waiting
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        req_op = 2'd0; req_addr = 8'h10; req_valid = 1'b1;
        @(posedge CLK); #1;
        check("bp.access_re", 8'(Read_EN), 8'h1);
        req_op = 2'd1; req_addr = 8'h20; req_wdata = 8'h3C;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            check($sformatf("bp%0d.rsp_valid", c), 8'(rsp_valid), 8'h1);
            check($sformatf("bp%0d.rsp_data", c), rsp_data, 8'hA5);
            check($sformatf("bp%0d.req_ready", c), 8'(req_ready), 8'h0);
            check($sformatf("bp%0d.strobes", c), 8'({Write_EN, Read_EN}), 8'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.req_ready_follow", 8'(req_ready), 8'h1);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        check("bp.next_we", 8'(Write_EN), 8'h1);
        check("bp.next_a", A, 8'h20);
        check("bp.next_wd", WD, 8'h3C);
        check("bp.old_rsp_gone", 8'(rsp_valid), 8'h0);
        @(posedge CLK); #1;
        check("bp.next_rsp", 8'({rsp_valid, rsp_err}), 8'h2);

        // Reset during ACCESS of a PUSH
        @(posedge CLK); #1;
        req_op = 2'd2; req_wdata = 8'h77; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        check("mr.we_before", 8'(Write_EN), 8'h1);
        #2 RST = 1'b0;
        #1;
        check("mr.we_async_drop", 8'(Write_EN), 8'h0);
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        check("mr.sp", sp, 8'hFF);
        check("mr.rsp_valid", 8'(rsp_valid), 8'h0);
        check("mr.stk_err", 8'(stk_err), 8'h0);
        check("mr.req_ready", 8'(req_ready), 8'h1);
        do_op("mr.load20", 2'd0, 8'h20, 8'h00, 1'b0, 1'b1, 8'h20, 8'h3C, 1'b0, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
